instr_encoder_ls_shift: RTL and testbench
=========================================

// Module: instr_encoder_ls_shift
// PURPOSE
//  Encoder and program loader for the RV32I lw/sw/shift subset, producing words that decoder_load_store_shift consumes.
//  - Accepts an operation plus register and immediate fields over a valid/ready handshake.
//  - Packs them into a 32-bit RV32I word and writes it to sequential instruction-memory addresses.
//  - Lets testbenches and boot logic fill instruction memory without hand-assembled hex.
// PARAMETERS
//  ADDR_W     8   instruction-memory word-address width; capacity = 2**ADDR_W words
//  BASE_ADDR  0   word address loaded into the write pointer on reset and on start_i
// PORTS
//  clk_i        in   1       clock; all logic on rising edge
//  rst_ni       in   1       synchronous reset, active low
//  start_i      in   1       reload pointer to BASE_ADDR, clear count_o, leave FULL
//  op_valid_i   in   1       operation fields valid
//  op_ready_o   out  1       block can accept an operation this cycle
//  op_i         in   3       0 LW, 1 SW, 2 SLL, 3 SRL, 4 SRA, 5 SLLI, 6 SRLI, 7 SRAI
//  rd_i         in   5       destination register (ignored for SW)
//  rs1_i        in   5       source register 1
//  rs2_i        in   5       source register 2 (used by SW and R-type shifts)
//  imm_i        in   32      offset (LW/SW, signed) or shamt (I-type shifts)
//  mem_we_o     out  1       memory write request
//  mem_addr_o   out  ADDR_W  word address of current write
//  mem_wdata_o  out  32      encoded instruction
//  mem_ack_i    in   1       memory accepted the write
//  err_o        out  1       one-cycle pulse: operation rejected (immediate out of range)
//  count_o      out  ADDR_W+1  words written since reset/start
//  full_o       out  1       memory full; no further operations accepted
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge):
//   - State IDLE; pointer=BASE_ADDR; mem_wdata_o=0; count_o=0.
//   - mem_we_o, err_o, full_o = 0; op_ready_o = 1 in the cycle after reset.
//   - Reset in WRITE abandons the write: mem_we_o is 0 the next cycle and the pointer does not advance.
//  FSM:
//   - IDLE: op_ready_o=1.
//     - Accept when op_valid_i & op_ready_o. Encode the word and check range.
//     - Illegal: err_o=1 next cycle, no write, stay IDLE.
//     - Legal: register word into mem_wdata_o, go WRITE.
//   - WRITE: op_ready_o=0; mem_we_o=1; mem_addr_o and mem_wdata_o held stable until mem_ack_i.
//     - On mem_ack_i: pointer+1 (wraps modulo 2**ADDR_W), count_o+1.
//     - Next state FULL if count_o becomes 2**ADDR_W, else IDLE.
//     - Throughput: at most 1 word per 2 cycles.
//   - FULL: op_ready_o=0, full_o=1. Stay until start_i.
//  start_i:
//   - Honoured in IDLE and FULL: next state IDLE, pointer=BASE_ADDR, count_o=0, full_o=0.
//   - Ignored in WRITE.
//   - If start_i and op_valid_i both occur in IDLE, start wins and the op is not accepted.
//  Encoding (fields not listed are 0):
//   - LW:  {imm[11:0],rs1,3'b010,rd,7'b0000011}
//   - SW:  {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}
//   - SLL/SRL/SRA:    {f7,rs2,rs1,f3,rd,7'b0110011}
//   - SLLI/SRLI/SRAI: {f7,imm[4:0],rs1,f3,rd,7'b0010011}
//   - f3: 001 for left shifts, 101 for right shifts.
//   - f7: 0100000 for SRA/SRAI, otherwise 0000000.
//  Range check (accepted ops are legal unless they fail):
//   - LW/SW: imm_i in [-2048, 2047], i.e. imm_i[31:11] all equal.
//   - I-type shifts: imm_i[31:5] == 0.
//   - R-type shifts: imm_i ignored, never illegal.
// TESTING
//  - LW rd=5 rs1=2 imm=8, ack same cycle -> addr 0 written with 0x00812283, count_o=1.
//  - SW rs2=6 rs1=1 imm=-4, ack after 3 cycles -> 0xFE60AE23 held stable until ack, addr 1.
//  - SRAI rd=7 rs1=3 imm=4 -> 0x4041D393; SRA rd=1 rs1=2 rs2=3 -> 0x403150B3.
//  - SLLI imm=32, then LW imm=2048 -> err_o pulses twice, mem_we_o stays 0, count_o unchanged.
//  - ADDR_W=2: 4 writes -> full_o=1, op_ready_o=0; start_i -> count_o=0, next write at BASE_ADDR.
//  - rst_ni=0 while WRITE awaits ack -> mem_we_o=0 next cycle, count_o=0, op_ready_o=1.

Source files
------------

// File: rtl/instr_encoder_ls_shift.sv
// Encoder/loader for the RV32I lw/sw/shift subset: packs operation fields into
// 32-bit words and writes them to consecutive instruction-memory addresses.
module instr_encoder_ls_shift #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [2:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              err_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_SLLI = 3'd5;
    localparam logic [2:0] OP_SRAI = 3'd7;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [31:0]         wdata_q;
    logic                err_q;

    logic [31:0]         word_d;
    logic                legal_d;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [ADDR_W:0]     count_inc;

    // Shift direction and arithmetic flag are shared by the R- and I-type forms.
    always_comb begin
        funct3 = ((op_i == OP_SLL) || (op_i == OP_SLLI)) ? 3'b001 : 3'b101;
        funct7 = ((op_i == OP_SRA) || (op_i == OP_SRAI)) ? 7'b0100000 : 7'b0000000;
        word_d  = 32'd0;
        legal_d = 1'b1;
        case (op_i)
            OP_LW: begin
                word_d  = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
                legal_d = (&imm_i[31:11]) | ~(|imm_i[31:11]);
            end
            OP_SW: begin
                word_d  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
                legal_d = (&imm_i[31:11]) | ~(|imm_i[31:11]);
            end
            3'd2, 3'd3, 3'd4: begin
                word_d  = {funct7, rs2_i, rs1_i, funct3, rd_i, 7'b0110011};
                legal_d = 1'b1;
            end
            default: begin
                word_d  = {funct7, imm_i[4:0], rs1_i, funct3, rd_i, 7'b0010011};
                legal_d = ~(|imm_i[31:5]);
            end
        endcase
    end

    assign count_inc = count_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE_ADDR;
            count_q <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ptr_q   <= BASE_ADDR;
                        count_q <= '0;
                    end else if (op_valid_i) begin
                        if (legal_d) begin
                            wdata_q <= word_d;
                            state_q <= ST_WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // start_i is deliberately not looked at while a write is pending.
                    if (mem_ack_i) begin
                        ptr_q   <= ptr_q + ADDR_W'(1);
                        count_q <= count_inc;
                        state_q <= (count_inc == CAPACITY) ? ST_FULL : ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (start_i) begin
                        ptr_q   <= BASE_ADDR;
                        count_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_ready_o  = (state_q == ST_IDLE);
    assign mem_we_o    = (state_q == ST_WRITE);
    assign full_o      = (state_q == ST_FULL);
    assign mem_addr_o  = ptr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder_ls_shift.sv
// Bench for instr_encoder_ls_shift: directed vector table, corner sequences and
// random traffic, all checked cycle by cycle against a behavioural model.
module tb_instr_encoder_ls_shift;

    localparam int              AW   = 2;
    localparam int              CAP  = 1 << AW;
    localparam logic [AW-1:0]   BASE = '0;

    logic          clk_i = 1'b0;
    logic          rst_ni, start_i, op_valid_i, mem_ack_i;
    logic [2:0]    op_i;
    logic [4:0]    rd_i, rs1_i, rs2_i;
    logic [31:0]   imm_i;
    logic          op_ready_o, mem_we_o, err_o, full_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [AW:0]   count_o;

    instr_encoder_ls_shift #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .err_o(err_o), .count_o(count_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a pending write flag, a full flag, pointer and word count.
    bit          m_busy, m_full, m_err;
    int          m_ptr, m_count;
    logic [31:0] m_word;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
        bit          legal;
    } vec_t;
    vec_t vecs[15];

    function automatic bit ref_legal(input logic [2:0] op, input logic [31:0] imm);
        if (op <= 3'd1) return ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
        if (op >= 3'd5) return imm < 32;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        int unsigned f3, f7, w;
        f3 = (op == 3'd2 || op == 3'd5) ? 1 : 5;
        f7 = (op == 3'd4 || op == 3'd7) ? 32 : 0;
        case (op)
            3'd0: w = 3 + rd * 128 + 2 * 4096 + rs1 * 32768 + (imm % 4096) * (1 << 20);
            3'd1: w = 35 + (imm % 32) * 128 + 2 * 4096 + rs1 * 32768 + rs2 * (1 << 20)
                      + ((imm / 32) % 128) * (1 << 25);
            3'd2, 3'd3, 3'd4:
                  w = 51 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (1 << 20) + f7 * (1 << 25);
            default:
                  w = 19 + rd * 128 + f3 * 4096 + rs1 * 32768 + (imm % 32) * (1 << 20)
                      + f7 * (1 << 25);
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit rst, input bit st, input bit vld, input logic [2:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input bit ack);
        rst_ni = ~rst; start_i = st; op_valid_i = vld; op_i = op;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm; mem_ack_i = ack;
        if (rst) begin
            m_busy = 0; m_full = 0; m_err = 0; m_ptr = BASE; m_count = 0; m_word = 32'd0;
        end else begin
            m_err = 0;
            if (m_busy) begin
                if (ack) begin
                    $display("write addr=%0d data=%08h count=%0d", m_ptr, m_word, m_count + 1);
                    m_ptr   = (m_ptr + 1) % CAP;
                    m_count = m_count + 1;
                    m_busy  = 0;
                    m_full  = (m_count == CAP);
                end
            end else if (m_full) begin
                if (st) begin
                    m_full = 0; m_ptr = BASE; m_count = 0;
                end
            end else if (st) begin
                m_ptr = BASE; m_count = 0;
            end else if (vld) begin
                if (ref_legal(op, imm)) begin
                    m_busy = 1;
                    m_word = ref_enc(op, rd, rs1, rs2, imm);
                end else begin
                    m_err = 1;
                    $display("reject op=%0d imm=%08h", op, imm);
                end
            end
        end
        @(posedge clk_i);
        #1;
        chk("status{ready,we,full,err,count}",
            {op_ready_o, mem_we_o, full_o, err_o, count_o},
            {(!m_busy && !m_full), m_busy, m_full, m_err, (AW+1)'(m_count)});
        chk("addr_wdata", {mem_addr_o, mem_wdata_o}, {AW'(m_ptr), m_word});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 31));
            1: return 32'($urandom_range(0, 4095)) - 32'd2048;
            2: return 32'd32;
            3: return 32'hFFFF_F7FF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        vecs[0]  = '{3'd0, 5'd5, 5'd2, 5'd0, 32'd8,          32'h00812283, 1'b1};
        vecs[1]  = '{3'd1, 5'd9, 5'd1, 5'd6, 32'hFFFF_FFFC,  32'hFE60AE23, 1'b1};
        vecs[2]  = '{3'd7, 5'd7, 5'd3, 5'd0, 32'd4,          32'h4041D393, 1'b1};
        vecs[3]  = '{3'd4, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF,  32'h403150B3, 1'b1};
        vecs[4]  = '{3'd5, 5'd0, 5'd0, 5'd0, 32'd32,         32'h0,        1'b0};
        vecs[5]  = '{3'd0, 5'd0, 5'd0, 5'd0, 32'd2048,       32'h0,        1'b0};
        vecs[6]  = '{3'd2, 5'd1, 5'd2, 5'd3, 32'd0,          32'h003110B3, 1'b1};
        vecs[7]  = '{3'd3, 5'd1, 5'd2, 5'd3, 32'd0,          32'h003150B3, 1'b1};
        vecs[8]  = '{3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800,  32'h80002003, 1'b1};
        vecs[9]  = '{3'd1, 5'd0, 5'd0, 5'd0, 32'd2047,       32'h7E002FA3, 1'b1};
        vecs[10] = '{3'd6, 5'd0, 5'd0, 5'd0, 32'd31,         32'h01F05013, 1'b1};
        vecs[11] = '{3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F7FF,  32'h0,        1'b0};
        vecs[12] = '{3'd5, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'h0,        1'b0};
        vecs[13] = '{3'd7, 5'd0, 5'd0, 5'd0, 32'h7FFF_FFE0,  32'h0,        1'b0};
        vecs[14] = '{3'd5, 5'd1, 5'd1, 5'd0, 32'd1,          32'h00109093, 1'b1};

        // Reset state
        cycle(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
        cycle(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
        chk("reset_ready", {op_ready_o, mem_we_o, full_o, err_o}, 4'b1000);

        // Vector table; start_i clears the block whenever it fills up
        for (int i = 0; i < 15; i++) begin
            int d;
            if (m_full) begin
                chk("full_flags", {full_o, op_ready_o}, 2'b10);
                cycle(0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
                chk("restart_addr", mem_addr_o, BASE);
            end
            cycle(0, 0, 1, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 0);
            if (vecs[i].legal) begin
                chk($sformatf("vec%0d_word", i), {mem_we_o, mem_wdata_o}, {1'b1, vecs[i].word});
                d = (i == 1) ? 3 : i % 3;
                for (int k = 0; k < d; k++) cycle(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
                chk($sformatf("vec%0d_held", i), mem_wdata_o, vecs[i].word);
                cycle(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1);
            end else begin
                chk($sformatf("vec%0d_err", i), {err_o, mem_we_o}, 2'b10);
                idle(1);
            end
        end
        if (m_full) cycle(0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);

        // start_i together with op_valid_i in IDLE: start wins
        cycle(0, 1, 1, 3'd0, 5'd5, 5'd2, 5'd0, 32'd8, 0);
        chk("start_beats_op", {mem_we_o, count_o}, {1'b0, (AW+1)'(0)});

        // start_i ignored during WRITE, then back-to-back writes with immediate ack
        cycle(0, 0, 1, 3'd2, 5'd1, 5'd2, 5'd3, 32'd0, 0);
        cycle(0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1);
        chk("start_in_write", count_o, (AW+1)'(1));
        cycle(0, 0, 1, 3'd3, 5'd4, 5'd5, 5'd6, 32'd0, 0);
        cycle(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1);

        // Reset while a write awaits ack abandons it
        cycle(0, 0, 1, 3'd0, 5'd5, 5'd2, 5'd0, 32'd8, 0);
        cycle(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
        cycle(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1);
        chk("rst_in_write", {mem_we_o, op_ready_o, count_o, mem_addr_o},
            {1'b0, 1'b1, (AW+1)'(0), BASE});

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  5'($urandom()), 5'($urandom()), 5'($urandom()), rand_imm(),
                  $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
